// File: rtl/dsp_addsub_simd_pipe.sv
// SIMD add/sub with per-lane wrap or signed saturation, STAGES-deep pipeline
// under one global stall (adv), plus a sticky per-lane overflow accumulator.

module dsp_addsub_simd_pipe_lane #(
  parameter int W = 12
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  input  logic         sat_i,
  output logic [W-1:0] res_o,
  output logic         ovf_o
);
  logic [W:0] ext_a, ext_b, sum;

  always_comb begin
    ext_a = {a_i[W-1], a_i};
    ext_b = {b_i[W-1], b_i};
    sum   = sub_i ? (ext_a - ext_b) : (ext_a + ext_b);
    // Exact result fits in W bits iff the two top bits of the W+1 sum agree.
    ovf_o = sum[W] ^ sum[W-1];
    if (ovf_o && sat_i)
      res_o = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      res_o = sum[W-1:0];
  end
endmodule

module dsp_addsub_simd_pipe #(
  parameter int LANES  = 4,
  parameter int LANE_W = 12,
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*LANES*LANE_W-1:0] inputs,
  input  logic [LANES-1:0]          op,
  input  logic                      sat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   ap_return,
  output logic [LANES-1:0]          ovf,
  output logic [LANES-1:0]          ovf_sticky,
  input  logic                      clr_sticky
);
  localparam int DW = LANES * LANE_W;

  logic                           adv;
  logic [LANES-1:0][LANE_W-1:0]   lane_res;
  logic [LANES-1:0]               lane_ovf;
  logic [STAGES:1]                vld_pipe_q, vld_pipe_d;
  logic [STAGES:1][DW-1:0]        dat_q, dat_d;
  logic [STAGES:1][LANES-1:0]     ovf_q, ovf_d;
  logic [LANES-1:0]               sticky_q, sticky_d;

  assign adv      = ce & (out_ready | ~out_valid);
  assign in_ready = adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dsp_addsub_simd_pipe_lane #(.W(LANE_W)) u_lane (
      .a_i   (inputs[2*i*LANE_W +: LANE_W]),
      .b_i   (inputs[(2*i+1)*LANE_W +: LANE_W]),
      .sub_i (op[i]),
      .sat_i (sat),
      .res_o (lane_res[i]),
      .ovf_o (lane_ovf[i])
    );
  end

  // Stage 1 captures the lane results with lane 0 packed into the MSBs;
  // later stages are a plain shift, all gated by the single adv enable.
  always_comb begin
    vld_pipe_d    = '0;
    dat_d         = '0;
    ovf_d         = '0;
    vld_pipe_d[1] = in_valid;
    ovf_d[1]      = lane_ovf;
    for (int i = 0; i < LANES; i++)
      dat_d[1][(LANES-1-i)*LANE_W +: LANE_W] = lane_res[i];
    for (int k = 2; k <= STAGES; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      dat_d[k]      = dat_q[k-1];
      ovf_d[k]      = ovf_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      dat_q      <= '0;
      ovf_q      <= '0;
    end else if (adv) begin
      vld_pipe_q <= vld_pipe_d;
      dat_q      <= dat_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = vld_pipe_q[STAGES];
  assign ap_return = dat_q[STAGES];
  assign ovf       = ovf_q[STAGES];

  // Clear wins over a same-cycle set; both are frozen while ce is low.
  always_comb begin
    sticky_d = sticky_q;
    if (ce) begin
      if (clr_sticky)
        sticky_d = '0;
      else if (out_valid && out_ready)
        sticky_d = sticky_q | ovf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sticky_q <= '0;
    else      sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
endmodule
